// File: rtl/i2s_mstr_tx.sv
// I2S master transmitter: divides clk down to the bit clock and serialises 24-bit
// left/right pairs from a one-deep holding buffer, 64 sclk per frame, MSB first.
module i2s_mstr_tx #(
  parameter int SCLK_DIV = 8,
  parameter int DATA_W   = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] lft_smpl,
  input  logic signed [DATA_W-1:0] rght_smpl,
  input  logic                     smpl_vld,
  output logic                     smpl_rdy,
  output logic                     I2S_sclk,
  output logic                     I2S_ws,
  output logic                     I2S_data,
  output logic                     frm_strt,
  output logic                     underrun
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCLK_DIV - 1);
  localparam int PAD_W = 32 - DATA_W;

  logic [DIV_W-1:0]         div_cnt;
  logic                     div_tc;
  logic                     fall_evt;
  logic [5:0]               bit_pos;
  logic [5:0]               bit_pos_nxt;
  logic                     frm_load;
  logic                     buf_full;
  logic                     smpl_acc;
  logic signed [DATA_W-1:0] buf_lft;
  logic signed [DATA_W-1:0] buf_rght;
  logic [63:0]              frm_sr;
  logic [63:0]              load_word;

  // Word select is high for the right slot, asserted one bit ahead of its MSB.
  function automatic logic ws_at(input logic [5:0] p);
    return (p >= 6'd31) && (p <= 6'd62);
  endfunction

  // Whole-frame bit sequence: each word is left-justified in its 32-bit slot.
  function automatic logic [63:0] pack_frame(input logic signed [DATA_W-1:0] l,
                                             input logic signed [DATA_W-1:0] r);
    return {l, {PAD_W{1'b0}}, r, {PAD_W{1'b0}}};
  endfunction

  assign div_tc      = (div_cnt == DIV_TC);
  assign fall_evt    = div_tc & I2S_sclk;
  assign bit_pos_nxt = bit_pos + 6'd1;
  assign frm_load    = fall_evt & (bit_pos == 6'd63);
  assign smpl_rdy    = ~buf_full;
  assign smpl_acc    = smpl_vld & ~buf_full;
  assign load_word   = buf_full ? pack_frame(buf_lft, buf_rght) : 64'd0;

  // Bit clock generation: free-running from reset, no enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      I2S_sclk <= 1'b0;
    end else if (div_tc) begin
      div_cnt  <= '0;
      I2S_sclk <= ~I2S_sclk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Serial side: everything the receiver sees changes only on sclk falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_pos  <= 6'd63;
      I2S_ws   <= 1'b0;
      I2S_data <= 1'b0;
      frm_strt <= 1'b0;
      underrun <= 1'b0;
      frm_sr   <= '0;
    end else begin
      frm_strt <= 1'b0;
      underrun <= 1'b0;
      if (fall_evt) begin
        bit_pos <= bit_pos_nxt;
        I2S_ws  <= ws_at(bit_pos_nxt);
        if (frm_load) begin
          // The MSB goes out in the load cycle itself, so it bypasses the register.
          frm_strt <= 1'b1;
          underrun <= ~buf_full;
          I2S_data <= load_word[63];
          frm_sr   <= {load_word[62:0], 1'b0};
        end else begin
          I2S_data <= frm_sr[63];
          frm_sr   <= {frm_sr[62:0], 1'b0};
        end
      end
    end
  end

  // Holding buffer: a pair captured during an underrunning load waits for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_lft  <= '0;
      buf_rght <= '0;
    end else if (frm_load && buf_full) begin
      buf_full <= 1'b0;
    end else if (smpl_acc) begin
      buf_full <= 1'b1;
      buf_lft  <= lft_smpl;
      buf_rght <= rght_smpl;
    end
  end

endmodule

// File: tb/tb_i2s_mstr_tx.sv
// Bench for i2s_mstr_tx: two instances (SCLK_DIV 8 and 2) checked every clk against
// a timeline model of the frame, plus a rise-sampling I2S receiver on the first.
module tb_i2s_mstr_tx;

  localparam int DIV_A = 8;
  localparam int DIV_B = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [23:0] lft_a, rght_a, lft_b, rght_b;
  logic        vld_a, vld_b;
  logic        rdy_a, sclk_a, ws_a, data_a, fs_a, un_a;
  logic        rdy_b, sclk_b, ws_b, data_b, fs_b, un_b;

  i2s_mstr_tx #(.SCLK_DIV(DIV_A)) dut_a (
    .clk(clk), .rst(rst), .lft_smpl(lft_a), .rght_smpl(rght_a), .smpl_vld(vld_a),
    .smpl_rdy(rdy_a), .I2S_sclk(sclk_a), .I2S_ws(ws_a), .I2S_data(data_a),
    .frm_strt(fs_a), .underrun(un_a));

  i2s_mstr_tx #(.SCLK_DIV(DIV_B)) dut_b (
    .clk(clk), .rst(rst), .lft_smpl(lft_b), .rght_smpl(rght_b), .smpl_vld(vld_b),
    .smpl_rdy(rdy_b), .I2S_sclk(sclk_b), .I2S_ws(ws_b), .I2S_data(data_b),
    .frm_strt(fs_b), .underrun(un_b));

  int checks = 0;
  int failures = 0;
  string phase;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: clk edges since release, one-deep buffer, current frame pair.
  int          kc[2];
  bit          hfull[2];
  logic [47:0] hval[2];
  logic [47:0] frm[2];
  bit          fs_e[2];
  bit          un_e[2];
  bit          acc[2];

  function automatic int divof(input int u);
    return (u == 0) ? DIV_A : DIV_B;
  endfunction

  task automatic model_step(input int u, input bit r, input bit v, input logic [47:0] pair);
    int d;
    bit load;
    bit rdy0;
    d = divof(u);
    if (r) begin
      kc[u] = 0; hfull[u] = 0; frm[u] = '0; fs_e[u] = 0; un_e[u] = 0; acc[u] = 0;
      return;
    end
    kc[u]++;
    load = (kc[u] >= 2*d) && (((kc[u] - 2*d) % (128*d)) == 0);
    rdy0 = !hfull[u];
    fs_e[u] = load;
    un_e[u] = load && rdy0;
    if (load) begin
      frm[u] = hfull[u] ? hval[u] : 48'd0;
      hfull[u] = 0;
    end
    acc[u] = v && rdy0;
    if (acc[u]) begin
      hfull[u] = 1;
      hval[u] = pair;
    end
  endtask

  function automatic logic [5:0] exp_out(input int u);
    int d;
    int p;
    logic s, w, b;
    d = divof(u);
    p = (kc[u] / (2*d) + 63) % 64;
    s = ((kc[u] / d) % 2) == 1;
    w = (p >= 31) && (p <= 62);
    b = 1'b0;
    if (p <= 23) b = frm[u][47-p];
    else if (p >= 32 && p <= 55) b = frm[u][55-p];
    return {s, w, b, fs_e[u], un_e[u], !hfull[u]};
  endfunction

  // Receiver state (samples data on sclk rise, closes a frame when ws falls).
  logic [63:0] rx_sr = '0;
  logic        rx_ws_prev = 1'b0;
  logic        sclk_prev = 1'b0;
  logic [47:0] rx_q[$];

  int  a_mode;   // 0 idle, 1 hold one pair, 2 ramp, 3 random
  int  ramp_i;
  bit  b_rand;

  task automatic tick();
    @(negedge clk);
    model_step(0, rst, vld_a, {lft_a, rght_a});
    model_step(1, rst, vld_b, {lft_b, rght_b});
    chk({phase, "_a"}, 64'({sclk_a, ws_a, data_a, fs_a, un_a, rdy_a}), 64'(exp_out(0)));
    chk({phase, "_b"}, 64'({sclk_b, ws_b, data_b, fs_b, un_b, rdy_b}), 64'(exp_out(1)));
    if (sclk_a === 1'b1 && sclk_prev === 1'b0) begin
      rx_sr = {rx_sr[62:0], data_a};
      if (rx_ws_prev && ws_a === 1'b0) rx_q.push_back({rx_sr[63:40], rx_sr[31:8]});
      rx_ws_prev = (ws_a === 1'b1);
    end
    sclk_prev = sclk_a;
    case (a_mode)
      1: if (acc[0]) vld_a = 1'b0;
      2: if (acc[0]) begin
           ramp_i++;
           if (ramp_i > 10) vld_a = 1'b0;
           else begin lft_a = 24'(ramp_i); rght_a = 24'(ramp_i); end
         end
      3: begin
           vld_a = ($urandom % 4) == 0;
           lft_a = 24'($urandom);
           rght_a = 24'($urandom);
         end
      default: vld_a = 1'b0;
    endcase
    if (b_rand) begin
      vld_b = ($urandom % 6) == 0;
      lft_b = 24'($urandom);
      rght_b = 24'($urandom);
    end else if (acc[1]) vld_b = 1'b0;
  endtask

  initial begin
    int nun, nfs, nboth, n, ra, rb;
    logic [47:0] cpair;
    logic [47:0] nz[$];

    rst = 1'b1;
    phase = "reset";
    a_mode = 1; vld_a = 1'b1; lft_a = 24'hA5A5A5; rght_a = 24'h3C3C3C;
    b_rand = 0; vld_b = 1'b1; lft_b = 24'hA5A5A5; rght_b = 24'h3C3C3C;
    ramp_i = 0;
    repeat (3) tick();
    chk("rst_init", 64'({sclk_a, ws_a, data_a, fs_a, un_a, rdy_a}), 64'(6'b000001));

    // Single pair offered before the first frame.
    rst = 1'b0;
    phase = "single";
    rx_q.delete(); rx_ws_prev = 1'b0;
    repeat (2100) tick();
    if (rx_q.size() < 2) chk("single_rx_cnt", 64'(rx_q.size()), 64'd2);
    else begin
      chk("single_pair", 64'(rx_q[0]), 64'({24'hA5A5A5, 24'h3C3C3C}));
      chk("single_next_zero", 64'(rx_q[1]), 64'd0);
    end
    b_rand = 1;

    // Starved source: every frame zero, underrun with each frame start.
    phase = "underrun";
    a_mode = 0; vld_a = 1'b0;
    rx_q.delete();
    nun = 0; nfs = 0; nboth = 0;
    repeat (3 * 128 * DIV_A) begin
      tick();
      if (un_a === 1'b1) nun++;
      if (fs_a === 1'b1) nfs++;
      if (un_a === 1'b1 && fs_a === 1'b1) nboth++;
    end
    chk("und_cnt", 64'(nun), 64'd3);
    chk("und_fs_cnt", 64'(nfs), 64'd3);
    chk("und_fs_together", 64'(nboth), 64'd3);
    chk("und_frames", 64'(rx_q.size()), 64'd3);
    foreach (rx_q[i]) chk("und_zero", 64'(rx_q[i]), 64'd0);

    // Ramp streaming: source keeps vld up whenever it has data.
    phase = "stream";
    rx_q.delete();
    ramp_i = 1; lft_a = 24'd1; rght_a = 24'd1; vld_a = 1'b1; a_mode = 2;
    repeat (13 * 128 * DIV_A) tick();
    nz.delete();
    foreach (rx_q[i]) if (rx_q[i] != 48'd0) nz.push_back(rx_q[i]);
    chk("ramp_cnt", 64'(nz.size()), 64'd10);
    foreach (nz[i]) chk("ramp_pair", 64'(nz[i]), 64'({24'(i + 1), 24'(i + 1)}));

    // Collision: vld lands exactly on a load with the buffer empty.
    phase = "collide";
    a_mode = 1; vld_a = 1'b0;
    n = 0;
    while (!(!hfull[0] && (((kc[0] + 1 - 2*DIV_A) % (128*DIV_A)) == 0)) && n < 2000) begin
      tick();
      n++;
    end
    chk("coll_wait_timeout", 64'(n < 2000), 64'd1);
    cpair = {24'($urandom) | 24'h800000, 24'($urandom) | 24'h000001};
    {lft_a, rght_a} = cpair;
    vld_a = 1'b1;
    rx_q.delete();
    tick();
    chk("coll_und", 64'(un_a), 64'd1);
    chk("coll_fs", 64'(fs_a), 64'd1);
    chk("coll_rdy", 64'(rdy_a), 64'd0);
    repeat (2100) tick();
    if (rx_q.size() < 2) chk("coll_rx_cnt", 64'(rx_q.size()), 64'd2);
    else begin
      chk("coll_frame_zero", 64'(rx_q[0]), 64'd0);
      chk("coll_pair_next", 64'(rx_q[1]), 64'(cpair));
    end

    // Random traffic on both instances.
    phase = "random";
    a_mode = 3;
    repeat (4096) tick();

    // Reset in the middle of a frame, then time the first sclk rise.
    phase = "midrst";
    a_mode = 0; vld_a = 1'b0;
    repeat ($urandom_range(100, 900)) tick();
    rst = 1'b1;
    tick();
    chk("midrst_outs_a", 64'({sclk_a, ws_a, data_a, fs_a, un_a, rdy_a}), 64'(6'b000001));
    chk("midrst_outs_b", 64'({sclk_b, ws_b, data_b, fs_b, un_b, rdy_b}), 64'(6'b000001));
    tick();
    tick();
    rst = 1'b0;
    ra = 0; rb = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ra == 0 && sclk_a === 1'b1) ra = i;
      if (rb == 0 && sclk_b === 1'b1) rb = i;
    end
    chk("first_rise_a", 64'(ra), 64'(DIV_A));
    chk("first_rise_b", 64'(rb), 64'(DIV_B));

    phase = "post";
    a_mode = 1; vld_a = 1'b1; lft_a = 24'h123456; rght_a = 24'hFEDCBA;
    repeat (1100) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_mstr_tx.md
# i2s_mstr_tx

I2S master transmitter that generates I2S_sclk, I2S_ws and I2S_data from 24-bit left/right sample pairs. It is the transmit-side counterpart of the I2S slave receiver in the equalizer. It serves two purposes: as the audio-source model in full-chip benches, and as a driver for an external I2S DAC fed from the EQ output. Samples enter through a one-deep holding buffer with a valid/ready handshake; frames run continuously once reset is released.

## Interface
- SCLK_DIV, 8: clk cycles per I2S_sclk half-period (≥2). At 50 MHz: sclk = 3.125 MHz, fs = 48.8 kHz.
- clk  input  1  system clock, 50 MHz
- rst  input  1  synchronous, active-high reset
- lft_smpl  input  24  signed left sample
- rght_smpl  input  24  signed right sample
- smpl_vld  input  1  sample pair valid
- smpl_rdy  output  1  holding buffer empty; pair accepted when smpl_vld & smpl_rdy
- I2S_sclk  output  1  bit clock
- I2S_ws  output  1  word select: 0 = left, 1 = right
- I2S_data  output  1  serial data, MSB first
- frm_strt  output  1  one-clk pulse at the start of each frame
- underrun  output  1  one-clk pulse when a frame starts with an empty holding buffer

## Operation
- **Divider.** Counts 0..SCLK_DIV-1. At the terminal count, I2S_sclk toggles and the divider wraps. A 0→1 toggle is a rise event; a 1→0 toggle is a fall event.
- **Bit position.** p (6 bits) increments mod 64 on every fall event. 64 sclk per frame, 32 per slot.
- All of I2S_ws, I2S_data, frm_strt and underrun update only on fall events. The receiver samples on rise.
- **Word select.** I2S_ws = 1 for p ∈ 31..62, and 0 for p = 63 and p ∈ 0..30. ws leads the slot MSB by one bit (standard I2S).
- **Data.**
  - p 0..23: left bit 23−p.
  - p 24..31: 0.
  - p 32..55: right bit 55−p.
  - p 56..63: 0.
- **Frame load (fall event with p becoming 0).**
  - If the holding buffer is full: move the pair into the left/right shift registers, mark the buffer empty, and drive the left MSB in this same cycle.
  - If the buffer is empty: shift registers load 0, the whole frame transmits zeros, and underrun pulses.
  - frm_strt pulses in this cycle.
- **Holding buffer.**
  - smpl_rdy = buffer empty.
  - If smpl_vld & smpl_rdy in the frame-load cycle while the buffer is empty, the pair is captured into the buffer for the next frame, and the current frame still underruns.
  - A vld presented while rdy = 0 is ignored; the source must hold it.
- **States:** RUN only. There is no idle or enable: the divider and p run unconditionally out of reset.

## Timing
- **Reset values:**
  - I2S_sclk = 0, I2S_ws = 0, I2S_data = 0.
  - p = 63, divider = 0.
  - smpl_rdy = 1, frm_strt = 0, underrun = 0.
  - Holding buffer empty, shift registers 0.
- **First edges after rst deasserts:**
  - First rise at clk SCLK_DIV.
  - First fall, and the first frame load with p = 0, at clk 2·SCLK_DIV.
- **Frame period:** 128·SCLK_DIV clk (1024 at default).
- **Latency:** a pair accepted at clk t has its left MSB on I2S_data at the next frame-load fall event after t. At worst this is one frame period plus one clk.
- **smpl_rdy timing:** falls the cycle after acceptance and rises the cycle after the frame-load transfer.
- **Reset mid-frame:** the synchronous rst overrides everything on the next clk edge, and all outputs return to their reset values. The partial frame is abandoned and buffered data is discarded.

## Test plan
- **Reset:** assert rst for 3 clk mid-frame -> all outputs at their reset values on the following clk; first I2S_sclk rise exactly 8 clk after release.
- **Single pair:** lft = 0xA5A5A5, rght = 0x3C3C3C before the first frame -> a reference I2S slave model sampling on rise recovers both words. I2S_ws falls one sclk before the left MSB. Bits 24..31 and 56..63 are 0.
- **Underrun:** no samples supplied -> every frame is all-zero data, with underrun and frm_strt pulsing together every 1024 clk.
- **Streaming:** source issues vld whenever rdy is high, 10 ramp pairs 0x000001..0x00000A -> pairs are transmitted in order with no underrun after the first frame, and rdy is low between acceptance and the next frame load.
- **Collision:** vld asserted in the same clk as a frame load with an empty buffer -> underrun pulses, this frame is zero, and the pair appears in the next frame.
- **SCLK_DIV = 2:** sclk period is 4 clk, frame period 256 clk, ws/data edges occur only on sclk falls, and the single-pair check still passes.
